// File: rtl/snake_pkg.sv
// Shared direction/state codes for the snake game blocks (sequencer, game logic, display).
package snake_pkg;

   typedef enum logic [1:0] {
      DIR_LEFT  = 2'd0,
      DIR_RIGHT = 2'd1,
      DIR_UP    = 2'd2,
      DIR_DOWN  = 2'd3
   } dir_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_WON  = 2'd2,
      ST_LOST = 2'd3
   } state_t;

   // Left<->right and up<->down differ only in bit 0.
   function automatic dir_t opposite(input dir_t d);
      return dir_t'({d[1], ~d[0]});
   endfunction

endpackage

// File: rtl/game_sequencer_dir_queue.sv
// Two-entry FIFO of pending turn requests; push is ignored when full, pop when empty.
module dir_queue
   import snake_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic push,
   input  logic pop,
   input  dir_t din,
   output logic full,
   output logic empty,
   output dir_t head,
   output dir_t tail
);

   logic [1:0] count;
   dir_t       q0;
   dir_t       q1;
   logic       do_push;
   logic       do_pop;

   assign full    = (count == 2'd2);
   assign empty   = (count == 2'd0);
   assign head    = q0;
   assign tail    = full ? q1 : q0;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         q0    <= DIR_LEFT;
         q1    <= DIR_LEFT;
      end else if (clr) begin
         count <= '0;
      end else begin
         unique case ({do_push, do_pop})
            2'b10: begin
               if (empty) q0 <= din;
               else       q1 <= din;
               count <= count + 2'd1;
            end
            2'b01: begin
               q0    <= q1;
               count <= count - 2'd1;
            end
            // Simultaneous push/pop only reaches here with one entry held.
            2'b11:   q0 <= din;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/game_sequencer.sv
// Game step sequencer: button events, run/won/lost control, speed level and step tick,
// and the buffered turn direction handed to game logic.
module game_sequencer
   import snake_pkg::*;
#(
   parameter int unsigned TICK_BASE       = 3125000,
   parameter int unsigned TICK_STEP       = 250000,
   parameter int unsigned SCORE_PER_LEVEL = 3,
   parameter int unsigned MAX_LEVEL       = 7
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btnu,
   input  logic       btnd,
   input  logic       btnl,
   input  logic       btnr,
   input  logic [9:0] score,
   input  logic       won,
   input  logic       lost,
   output logic       tick,
   output logic [1:0] direction,
   output logic       game_rst,
   output logic [1:0] state,
   output logic [2:0] level
);

   localparam int unsigned CW = $clog2(TICK_BASE + 1);

   logic [3:0]    sync1, sync2, prev, evt;
   logic          evt_any;
   dir_t          evt_dir;
   state_t        state_q, state_n;
   logic [CW-1:0] cnt;
   logic [2:0]    level_q, level_n;
   logic [9:0]    score_lvl;
   dir_t          dir_q, ref_dir, q_head, q_tail;
   logic          q_full, q_empty, q_push, q_pop, q_clr;
   logic          expiry, tick_q, ended;

   function automatic logic [CW-1:0] period_of(input logic [2:0] l);
      return CW'(TICK_BASE) - CW'(l) * CW'(TICK_STEP);
   endfunction

   // Button bits ordered {r, l, u, d}; event fires on the synchronised rising edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
         prev  <= '0;
         evt   <= '0;
      end else begin
         sync1 <= {btnr, btnl, btnu, btnd};
         sync2 <= sync1;
         prev  <= sync2;
         evt   <= sync2 & ~prev;
      end
   end

   always_comb begin
      evt_any = |evt;
      evt_dir = DIR_LEFT;
      if      (evt[3]) evt_dir = DIR_RIGHT;
      else if (evt[2]) evt_dir = DIR_LEFT;
      else if (evt[1]) evt_dir = DIR_UP;
      else if (evt[0]) evt_dir = DIR_DOWN;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_n;
   end

   always_comb begin
      state_n = state_q;
      unique case (state_q)
         ST_IDLE: if (evt_any) state_n = ST_RUN;
         ST_RUN: begin
            if      (lost) state_n = ST_LOST;
            else if (won)  state_n = ST_WON;
         end
         ST_WON, ST_LOST: if (evt_any) state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   always_comb begin
      game_rst = 1'b0;
      if (state_q == ST_IDLE) game_rst = 1'b1;
      state     = state_q;
      tick      = tick_q;
      direction = dir_q;
      level     = level_q;
   end

   assign ended     = (state_q == ST_WON) || (state_q == ST_LOST);
   assign expiry    = (state_q == ST_RUN) && (cnt == '0);
   assign score_lvl = score / 10'(SCORE_PER_LEVEL);
   assign level_n   = (score_lvl > 10'(MAX_LEVEL)) ? 3'(MAX_LEVEL) : score_lvl[2:0];
   assign ref_dir   = q_empty ? dir_q : q_tail;
   assign q_push    = (state_q == ST_RUN) && evt_any && !q_full &&
                      (evt_dir != ref_dir) && (evt_dir != opposite(ref_dir));
   assign q_pop     = expiry && !q_empty;
   assign q_clr     = ended;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         level_q <= '0;
         dir_q   <= DIR_RIGHT;
         tick_q  <= 1'b0;
      end else begin
         // An expiry coinciding with game end yields no tick.
         tick_q <= expiry && (state_n == ST_RUN);
         if ((state_q == ST_IDLE) && evt_any) begin
            cnt <= period_of(level_q);
         end else if (expiry) begin
            level_q <= level_n;
            cnt     <= period_of(level_n) - CW'(1);
         end else if (state_q == ST_RUN) begin
            cnt <= cnt - CW'(1);
         end
         if (q_pop)                dir_q <= q_head;
         else if (ended && evt_any) dir_q <= DIR_RIGHT;
      end
   end

   dir_queue u_dir_queue (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (q_clr),
      .push  (q_push),
      .pop   (q_pop),
      .din   (evt_dir),
      .full  (q_full),
      .empty (q_empty),
      .head  (q_head),
      .tail  (q_tail)
   );

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: table of press/score rows feeding a tick scoreboard,
// plus hand sequences for reset, game end and restart.
module tb_game_sequencer;
   import snake_pkg::*;

   typedef struct packed {
      logic [1:0] dir;
      logic [7:0] gap;
      logic [2:0] lvl;
   } exp_t;

   typedef struct packed {
      logic [9:0]      score;
      logic [1:0]      n_press;
      logic [1:0]      n_exp;
      logic [2:0][3:0] presses;
      exp_t [2:0]      exps;
   } row_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       btnu = 1'b0, btnd = 1'b0, btnl = 1'b0, btnr = 1'b0;
   logic [9:0] score = '0;
   logic       won = 1'b0, lost = 1'b0;
   logic       tick, game_rst;
   logic [1:0] direction, state;
   logic [2:0] level;

   int         n_vec = 0;
   int         n_mis = 0;
   int         cyc = 0;
   int         last_mark = 0;
   logic [1:0] prev_st = 2'd0;
   exp_t       exp_q[$];
   row_t       rows[6];

   game_sequencer #(
      .TICK_BASE       (20),
      .TICK_STEP       (2),
      .SCORE_PER_LEVEL (3),
      .MAX_LEVEL       (7)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .btnu      (btnu),
      .btnd      (btnd),
      .btnl      (btnl),
      .btnr      (btnr),
      .score     (score),
      .won       (won),
      .lost      (lost),
      .tick      (tick),
      .direction (direction),
      .game_rst  (game_rst),
      .state     (state),
      .level     (level)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [1:0] d, input logic [7:0] g, input logic [2:0] l);
      return '{dir: d, gap: g, lvl: l};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Every cycle advance goes through here so ticks are always scored.
   task automatic step();
      exp_t e;
      @(negedge clk);
      cyc++;
      if (state == 2'd1 && prev_st != 2'd1) last_mark = cyc;
      prev_st = state;
      if (tick === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_tick", {31'd0, tick}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("tick_dir", {30'd0, direction}, {30'd0, e.dir});
            check("tick_gap", cyc - last_mark, {24'd0, e.gap});
            check("tick_level", {29'd0, level}, {29'd0, e.lvl});
         end
         last_mark = cyc;
      end
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Mask bits {r, l, u, d}.
   task automatic press(input logic [3:0] m);
      btnr = m[3]; btnl = m[2]; btnu = m[1]; btnd = m[0];
      steps(2);
      btnr = 1'b0; btnl = 1'b0; btnu = 1'b0; btnd = 1'b0;
      steps(2);
   endtask

   task automatic wait_state(input logic [1:0] s, input int budget);
      for (int i = 0; i < budget && state != s; i++) step();
      check("wait_state", {30'd0, state}, {30'd0, s});
   endtask

   task automatic wait_drain(input int budget);
      for (int i = 0; i < budget && exp_q.size() > 0; i++) step();
      check("sb_drain", exp_q.size(), 32'd0);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_state"}, {30'd0, state}, 32'd0);
      check({tag, "_game_rst"}, {31'd0, game_rst}, 32'd1);
      check({tag, "_tick"}, {31'd0, tick}, 32'd0);
      check({tag, "_direction"}, {30'd0, direction}, 32'd1);
   endtask

   initial begin
      exp_t x;
      x = '0;
      //             score   np    ne    presses {p2,p1,p0}             exps {e2,e1,e0}
      rows[0] = '{10'd0,    2'd1, 2'd1, {4'h0, 4'h0, 4'b0100}, {x, x, mk(2'd1, 8'd20, 3'd0)}};
      rows[1] = '{10'd0,    2'd1, 2'd1, {4'h0, 4'h0, 4'b1010}, {x, x, mk(2'd1, 8'd20, 3'd0)}};
      rows[2] = '{10'd0,    2'd2, 2'd2, {4'h0, 4'b0100, 4'b0010},
                  {x, mk(2'd0, 8'd20, 3'd0), mk(2'd2, 8'd20, 3'd0)}};
      rows[3] = '{10'd0,    2'd3, 2'd3, {4'b0010, 4'b0100, 4'b0010},
                  {mk(2'd0, 8'd20, 3'd0), mk(2'd0, 8'd20, 3'd0), mk(2'd2, 8'd20, 3'd0)}};
      rows[4] = '{10'd3,    2'd0, 2'd2, {4'h0, 4'h0, 4'h0},
                  {x, mk(2'd0, 8'd18, 3'd1), mk(2'd0, 8'd20, 3'd1)}};
      rows[5] = '{10'd1000, 2'd0, 2'd2, {4'h0, 4'h0, 4'h0},
                  {x, mk(2'd0, 8'd6, 3'd7), mk(2'd0, 8'd18, 3'd7)}};

      steps(3);
      check_idle("in_reset");
      check("in_reset_level", {29'd0, level}, 32'd0);
      rst_n = 1'b1;
      steps(2);
      check_idle("post_reset");

      // Reset mid-period with a pending turn: nothing may survive it.
      press(4'b0010);
      wait_state(2'd1, 10);
      check("run_game_rst", {31'd0, game_rst}, 32'd0);
      press(4'b0010);
      steps(3);
      #2 rst_n = 1'b0;
      #1;
      check_idle("async_reset");
      check("async_reset_level", {29'd0, level}, 32'd0);
      steps(5);
      rst_n = 1'b1;
      steps(30);
      check("after_release_state", {30'd0, state}, 32'd0);

      // Start a game: first tick lands one cycle after the loaded period runs out.
      exp_q.push_back(mk(2'd1, 8'd21, 3'd0));
      press(4'b0010);
      check("start_state", {30'd0, state}, 32'd1);
      check("start_game_rst", {31'd0, game_rst}, 32'd0);

      for (int r = 0; r < 6; r++) begin
         wait_drain(60);
         score = rows[r].score;
         for (int e = 0; e < int'(rows[r].n_exp); e++) exp_q.push_back(rows[r].exps[e]);
         for (int p = 0; p < int'(rows[r].n_press); p++) press(rows[r].presses[p]);
      end
      wait_drain(80);

      // Both end flags: lost wins, ticks stop, direction holds.
      won = 1'b1;
      lost = 1'b1;
      step();
      check("end_state", {30'd0, state}, 32'd3);
      steps(20);
      check("end_direction", {30'd0, direction}, 32'd0);
      won = 1'b0;
      lost = 1'b0;
      press(4'b0001);
      wait_state(2'd0, 10);
      check_idle("restart");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
